// File: rtl/ruleta_display_mux.sv
// ruleta_display_mux: roulette engine (spin -> constant-rate SPIN -> doubling-interval SLOW -> RESULT) driving a scanned active-low 7-seg bank; ports clk_main, reset, spin, stop -> value, busy, result_valid, seg[6:0]=a..g, an (an[0]=LSD); define RULETA_RESULT_BLINK_EN to blink the digits while in RESULT
module ruleta_display_mux #(
  parameter int NUM_VALUES  = 37,
  parameter int NUM_DIGITS  = 2,
  parameter int SPIN_DIV    = 50,
  parameter int SLOW_STEPS  = 8,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                          clk_main,
  input  logic                          reset,
  input  logic                          spin,
  input  logic                          stop,
  output logic [$clog2(NUM_VALUES)-1:0] value,
  output logic                          busy,
  output logic                          result_valid,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an
);
  localparam int VW = $clog2(NUM_VALUES);
  localparam int IW = SLOW_STEPS + $clog2(SPIN_DIV) + 2;
  localparam int CW = $clog2(SLOW_STEPS + 1);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SPIN, SLOW, RESULT} state_t;
  state_t state;
  logic [IW-1:0] tmr, ival;
  logic [CW-1:0] cnt;
  logic [VW-1:0] nxt_val;
  logic [RW-1:0] rtmr;
  logic [SW-1:0] scan, nxt_scan;
  logic [6:0] seg_r, seg_nxt;
  logic [31:0] vx;
  logic [3:0] dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blk;
  function automatic logic [6:0] enc(input logic [3:0] x);
    case (x)
      4'd0: enc = 7'b0000001;
      4'd1: enc = 7'b1001111;
      4'd2: enc = 7'b0010010;
      4'd3: enc = 7'b0000110;
      4'd4: enc = 7'b1001100;
      4'd5: enc = 7'b0100100;
      4'd6: enc = 7'b0100000;
      4'd7: enc = 7'b0001111;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0000100;
      default: enc = 7'b1111111;
    endcase
  endfunction
  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction
  assign vx = 32'(value);
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    localparam int P = pow10(d);
    assign dig[d] = 4'((vx / P) % 10);
    assign blk[d] = d > 0 && vx < P;
  end
  assign nxt_val  = value == VW'(NUM_VALUES - 1) ? '0 : value + 1'b1;
  assign nxt_scan = scan == SW'(NUM_DIGITS - 1) ? '0 : scan + 1'b1;
  assign seg_nxt  = blk[nxt_scan] ? 7'b1111111 : enc(dig[nxt_scan]);
  always_ff @(posedge clk_main) begin
    if (reset) begin
      state        <= IDLE;
      value        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      tmr          <= '0;
      ival         <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE, RESULT:
          if (spin) begin
            state        <= SPIN;
            tmr          <= '0;
            busy         <= 1'b1;
            result_valid <= 1'b0;
          end
        SPIN:
          if (stop) begin
            state <= SLOW;
            ival  <= IW'(2 * SPIN_DIV);
            tmr   <= '0;
            cnt   <= '0;
          end else if (tmr == IW'(SPIN_DIV - 1)) begin
            value <= nxt_val;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        SLOW:
          if (tmr == ival - 1'b1) begin
            value <= nxt_val;
            ival  <= ival << 1;
            tmr   <= '0;
            cnt   <= cnt + 1'b1;
            if (cnt + 1'b1 == CW'(SLOW_STEPS)) begin
              state        <= RESULT;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_main) begin
    if (reset) begin
      rtmr  <= '0;
      scan  <= '0;
      an    <= ~NUM_DIGITS'(1);
      seg_r <= 7'b0000001;
    end else if (rtmr == RW'(REFRESH_DIV - 1)) begin
      rtmr  <= '0;
      scan  <= nxt_scan;
      an    <= ~(NUM_DIGITS'(1) << nxt_scan);
      seg_r <= seg_nxt;
    end else begin
      rtmr <= rtmr + 1'b1;
    end
  end
`ifdef RULETA_RESULT_BLINK_EN
  localparam int BP = 16 * NUM_DIGITS * REFRESH_DIV;
  localparam int BW = $clog2(BP);
  logic [BW-1:0] bcnt;
  logic boff;
  always_ff @(posedge clk_main) begin
    if (reset || !result_valid) begin
      bcnt <= '0;
      boff <= 1'b1;
    end else if (bcnt == BW'(BP - 1)) begin
      bcnt <= '0;
      boff <= ~boff;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
  assign seg = seg_r | {7{boff & result_valid}};
`else
  assign seg = seg_r;
`endif
endmodule

// File: tb/tb_ruleta_display_mux.sv
// tb_ruleta_display_mux: directed stimulus with a cycle-level behavioural model and literal checks
module tb_ruleta_display_mux;
  localparam int NV = 37, ND = 2, SD = 4, SS = 3, RD = 2;
  localparam logic [6:0] SEGT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                       7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic clk_main = 1'b0, reset = 1'b1, spin = 1'b0, stop = 1'b0;
  logic [5:0] value;
  logic busy, result_valid;
  logic [6:0] seg;
  logic [1:0] an;
  int total = 0, bad = 0, cyc;
  bit chk_en = 0;
  int m_phase, m_val, left, gap, done, n, rc;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  ruleta_display_mux #(.NUM_VALUES(NV), .NUM_DIGITS(ND), .SPIN_DIV(SD), .SLOW_STEPS(SS), .REFRESH_DIV(RD)) dut (
    .clk_main(clk_main), .reset(reset), .spin(spin), .stop(stop), .value(value),
    .busy(busy), .result_valid(result_valid), .seg(seg), .an(an)
  );
  always #5 clk_main = ~clk_main;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [6:0] exp_seg();
`ifdef RULETA_RESULT_BLINK_EN
    if (m_phase == 3 && (rc / (16 * ND * RD)) % 2 == 0) return 7'b1111111;
`endif
    return m_seg;
  endfunction
  // phases: 0 idle, 1 spinning, 2 slowing, 3 result; left counts edges down to the next step
  always @(posedge clk_main) begin
    if (reset) begin
      m_phase = 0; m_val = 0; n = 0; rc = 0;
      m_an = 2'b10; m_seg = SEGT[0];
    end else begin
      n++;
      if (n % RD == 0) begin
        int slot, p;
        slot = (n / RD) % ND;
        p = 10 ** slot;
        m_an = 2'b11;
        m_an[slot] = 1'b0;
        m_seg = (slot > 0 && m_val < p) ? 7'b1111111 : SEGT[(m_val / p) % 10];
      end
      case (m_phase)
        0, 3: if (spin) begin m_phase = 1; left = SD; end else rc++;
        1: if (stop) begin
             m_phase = 2; gap = 2 * SD; left = gap; done = 0;
           end else begin
             left = left - 1;
             if (left == 0) begin m_val = (m_val + 1) % NV; left = SD; end
           end
        default: begin
          left = left - 1;
          if (left == 0) begin
            m_val = (m_val + 1) % NV; done++; gap = gap * 2; left = gap;
            if (done == SS) begin m_phase = 3; rc = 0; end
          end
        end
      endcase
    end
  end
  always @(negedge clk_main) begin
    if (chk_en) begin
      check("value", value, m_val);
      check("busy", busy, m_phase == 1 || m_phase == 2);
      check("result_valid", result_valid, m_phase == 3);
      check("an", an, m_an);
      check("seg", seg, exp_seg());
    end
  end
  task automatic wait_val(input int v, input int lim);
    int k;
    k = 0;
    while (value !== 6'(v) && k < lim) begin @(negedge clk_main); k++; end
    check("wait_value", value, v);
  endtask
  task automatic wait_an(input logic [1:0] a, input int lim);
    int k;
    k = 0;
    while (an !== a && k < lim) begin @(negedge clk_main); k++; end
    check("wait_an", an, a);
  endtask
  task automatic wait_rv(output int c);
    c = 0;
    while (result_valid !== 1'b1 && c < 300) begin @(negedge clk_main); c++; end
    check("wait_result", result_valid, 1);
  endtask
  task automatic pulse(input bit s, input bit t);
    spin = s; stop = t;
    @(negedge clk_main);
    spin = 0; stop = 0;
  endtask
  initial begin
    @(negedge clk_main);
    @(negedge clk_main);
    chk_en = 1;
    check("rst_value", value, 0);
    check("rst_an", an, 2'b10);
    check("rst_seg", seg, 7'b0000001);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    reset = 0;
    repeat (10) @(negedge clk_main);
    check("idle_value", value, 0);
    pulse(1, 0);
    check("spin_busy", busy, 1);
    wait_val(36, 200);
    wait_val(0, 10);
    wait_val(5, 40);
    pulse(0, 1);
    wait_rv(cyc);
    check("slow_cycles", cyc, 56);
    check("result_value", value, 8);
    check("result_busy", busy, 0);
    repeat (200) @(negedge clk_main);
    check("hold_value", value, 8);
    wait_an(2'b10, 10);
    check("seg8_lo", seg, 7'b0000000);
    wait_an(2'b01, 10);
    check("seg8_hi", seg, 7'b1111111);
    pulse(1, 0);
    check("respin_rv", result_valid, 0);
    wait_val(20, 100);
    pulse(0, 1);
    wait_rv(cyc);
    check("result23", value, 23);
    repeat (70) @(negedge clk_main);
    wait_an(2'b10, 10);
    check("seg23_lo", seg, 7'b0000110);
    wait_an(2'b01, 10);
    check("seg23_hi", seg, 7'b0010010);
    reset = 1;
    repeat (2) @(negedge clk_main);
    reset = 0;
    pulse(1, 1);
    check("both_busy", busy, 1);
    repeat (4) @(negedge clk_main);
    check("both_value", value, 1);
    pulse(0, 1);
    repeat (3) @(negedge clk_main);
    pulse(1, 1);
    wait_rv(cyc);
    check("slow_ign_cycles", cyc, 52);
    check("slow_ign_value", value, 4);
    pulse(1, 0);
    repeat (10) @(negedge clk_main);
    pulse(0, 1);
    repeat (12) @(negedge clk_main);
    reset = 1;
    @(negedge clk_main);
    check("abort_value", value, 0);
    check("abort_busy", busy, 0);
    check("abort_rv", result_valid, 0);
    reset = 0;
    repeat (100) @(negedge clk_main);
    check("abort_no_result", result_valid, 0);
    check("abort_idle_value", value, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ruleta_display_mux.md
Name: ruleta_display_mux

Overview:
Parametrised roulette engine with a multiplexed multi-digit 7-segment driver. Generalises the single-digit 0..5 roulette display:
- configurable value range and digit count;
- explicit spin/stop control;
- deceleration phase before the result is latched;
- time-multiplexed anode scanning.

It drives the board's 7-segment bank directly. It also exposes the result to game logic.

Parameters:
NUM_VALUES, 37, number of roulette positions; value range 0..NUM_VALUES-1; legal range 2..9999
NUM_DIGITS, 2, number of displayed digits; must satisfy 10^NUM_DIGITS >= NUM_VALUES
SPIN_DIV, 50, clk_main cycles per value step at full speed; minimum 1
SLOW_STEPS, 8, number of decelerating steps after stop; minimum 1
REFRESH_DIV, 1000, clk_main cycles each digit is enabled during scanning; minimum 1

Ports:
clk_main  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
spin  in  1  single-cycle pulse, start spinning
stop  in  1  single-cycle pulse, begin deceleration
value  out  VW=$clog2(NUM_VALUES)  current roulette position, binary
busy  out  1  high in SPIN or SLOW
result_valid  out  1  high in RESULT
seg  out  7  segments, active-low; bit6=a ... bit0=g
an  out  NUM_DIGITS  digit enables, active-low; an[0] is the least significant digit

Behaviour:
- Reset is synchronous and active-high on clk_main. On reset:
  - state=IDLE, value=0, busy=0, result_valid=0;
  - step timer=0, step count=0, scan index=0, refresh timer=0;
  - an = all ones except an[0]=0; seg=7'b0000001.
- Reset asserted mid-spin aborts immediately to the reset state. No result is produced.
- States and transitions:
  - IDLE: spin -> SPIN, step timer cleared.
  - SPIN: every SPIN_DIV cycles (step timer reaches SPIN_DIV-1), value increments and the timer clears. stop -> SLOW, with interval=2*SPIN_DIV, timer=0, step count=0.
  - SLOW: when the timer reaches interval-1, value increments, interval doubles, the timer clears, and step count increments. The step that makes step count = SLOW_STEPS transitions to RESULT in the same cycle.
  - RESULT: value is frozen and result_valid=1. spin -> SPIN (result_valid drops next cycle).
- Ignored inputs:
  - spin is ignored in SPIN and SLOW.
  - stop is ignored in IDLE, SLOW and RESULT.
  - spin and stop in the same cycle: in IDLE/RESULT, spin wins. In SPIN, stop wins.
- Wrap-around: a value increment from NUM_VALUES-1 wraps to 0, in both SPIN and SLOW.
- Interval register width must hold 2^SLOW_STEPS*SPIN_DIV without overflow.
- Outputs busy and result_valid are registered. They change in the cycle after the transition.
- Display scanning:
  - The refresh timer counts 0..REFRESH_DIV-1. On wrap, scan index advances (NUM_DIGITS-1 wraps to 0).
  - an and seg are registered and update on that same edge. Exactly one an bit is low at all times.
- Digit content: digit d shows (value / 10^d) % 10.
- Leading-zero blanking: digit d>0 shows seg=7'b1111111 when value < 10^d. Digit 0 always shows a number.
- Decimal encoding (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Display latency: a value change appears on a digit at its next scan slot. Worst case is NUM_DIGITS*REFRESH_DIV cycles.

Optional Feature:
Macro RULETA_RESULT_BLINK_EN.
- Defined: in RESULT, all digits blank (seg=7'b1111111, an still scans) during alternate periods of 16*NUM_DIGITS*REFRESH_DIV cycles. The first period after entering RESULT is blank. Blinking stops on leaving RESULT.
- Undefined: RESULT displays steadily. No blink counter is synthesised.

Test Plan:
All scenarios use NUM_VALUES=37, NUM_DIGITS=2, SPIN_DIV=4, SLOW_STEPS=3, REFRESH_DIV=2.
- Reset -> value=0, busy=0, result_valid=0, an=2'b10, seg=7'b0000001. Hold 10 cycles idle -> value remains 0.
- Spin pulse -> busy=1 next cycle. Value increments every 4 cycles. After 36 steps the value wraps 36->0.
- Stop when value=5 -> steps occur 8, 16, 32 cycles apart -> value=8, result_valid=1, busy=0. Value is stable for 200 further cycles.
- Value=8 scanning -> an=10 gives seg=0000000 ("8"); an=01 gives seg=1111111 (blank). Value=23 -> an=10 gives 0000110, an=01 gives 0010010.
- Spin and stop in the same cycle from IDLE -> enters SPIN. Stop during SLOW -> no change to step spacing.
- Reset asserted during SLOW -> next cycle value=0, IDLE, result_valid never asserts. With RULETA_RESULT_BLINK_EN defined, RESULT shows blank for 64 cycles then the digits.
